// File: rtl/mand_pkg.sv
// Shared definitions for the Mandelbrot pass sequencer: FSM states,
// CSR window addresses and CTRL register bit positions.
package mand_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ISSUE    = 3'd1,
        ST_DRAIN    = 3'd2,
        ST_PASS_END = 3'd3,
        ST_DONE     = 3'd4
    } state_t;

    localparam logic [1:0] CSR_CTRL   = 2'd0;
    localparam logic [1:0] CSR_PASSES = 2'd1;
    localparam logic [1:0] CSR_STATUS = 2'd2;
    localparam logic [1:0] CSR_INDEX  = 2'd3;

    localparam int CTRL_START   = 0;
    localparam int CTRL_ABORT   = 1;
    localparam int CTRL_IRQ_CLR = 2;

endpackage

// File: rtl/mand_delay.sv
// Resettable shift register that delays a bus by DEPTH cycles. Used to
// turn the read strobe/index into the result-memory write strobe/index.
module mand_delay #(
    parameter int WIDTH = 15,
    parameter int DEPTH = 17
) (
    input  logic             clock,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] pipe [DEPTH];

    // Shift one stage per cycle; reset flushes every stage so no stale write escapes.
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) pipe[i] <= '0;
        end else begin
            pipe[0] <= din;
            for (int i = 1; i < DEPTH; i++) pipe[i] <= pipe[i-1];
        end
    end

    assign dout = pipe[DEPTH-1];

endmodule

// File: rtl/mand_sequencer.sv
// Pass sequencer for the Mandelbrot engine: sweeps the point index over the
// whole memory, drains the engine pipeline between passes, repeats for the
// programmed pass count and exposes a small CSR window for control/status.
module mand_sequencer
    import mand_pkg::*;
#(
    parameter int ADDR_W  = 14,
    parameter int LATENCY = 17,
    parameter int PASS_W  = 10
) (
    input  logic              clock,
    input  logic              rst,
    input  logic              csr_write,
    input  logic [1:0]        csr_addr,
    input  logic [31:0]       csr_data_in,
    output logic [31:0]       csr_data_out,
    output logic [ADDR_W-1:0] rd_index,
    output logic              rd_valid,
    output logic [ADDR_W-1:0] wr_index,
    output logic              wr_en,
    output logic              busy,
    output logic              irq
);

    localparam int DRAIN_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(LATENCY - 1);

    state_t              state, next_state;
    logic [PASS_W-1:0]   pass_cnt;
    logic [PASS_W-1:0]   passes;
    logic [DRAIN_W-1:0]  drain_cnt;
    logic                abort_pend;

    logic                ctrl_wr, start_req, abort_req, clr_req;
    logic                last_index, drain_last, last_pass;
    logic [PASS_W-1:0]   pass_next, passes_eff;
    logic [ADDR_W:0]     wr_bus;
    logic                unused_data_bits;

    // CTRL decode: abort dominates start in the same write.
    assign ctrl_wr    = csr_write && (csr_addr == CSR_CTRL);
    assign start_req  = ctrl_wr && csr_data_in[CTRL_START] && !csr_data_in[CTRL_ABORT];
    assign abort_req  = ctrl_wr && csr_data_in[CTRL_ABORT];
    assign clr_req    = ctrl_wr && csr_data_in[CTRL_IRQ_CLR];

    assign last_index = (rd_index == {ADDR_W{1'b1}});
    assign drain_last = (drain_cnt == DRAIN_LAST);
    assign pass_next  = pass_cnt + 1'b1;
    assign passes_eff = (passes == '0) ? PASS_W'(1) : passes;
    assign last_pass  = (pass_next == passes_eff);

    assign rd_valid   = (state == ST_ISSUE);
    assign unused_data_bits = ^csr_data_in[31:PASS_W];

    // State register.
    always_ff @(posedge clock or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= next_state;
    end

    // Next-state logic for the sweep / drain / pass accounting sequence.
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:     if (start_req) next_state = ST_ISSUE;
            ST_ISSUE:    if (abort_req || last_index) next_state = ST_DRAIN;
            ST_DRAIN:    if (drain_last)
                             next_state = (abort_pend || abort_req) ? ST_IDLE : ST_PASS_END;
            ST_PASS_END: next_state = last_pass ? ST_DONE : ST_ISSUE;
            ST_DONE:     next_state = ST_IDLE;
            default:     next_state = ST_IDLE;
        endcase
    end

    // Index, drain and pass counters plus the abort memory.
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            rd_index   <= '0;
            drain_cnt  <= '0;
            pass_cnt   <= '0;
            abort_pend <= 1'b0;
        end else begin
            if (state == ST_ISSUE) rd_index <= rd_index + 1'b1;
            else if (state == ST_IDLE) rd_index <= '0;

            if (state == ST_DRAIN) drain_cnt <= drain_cnt + 1'b1;
            else                   drain_cnt <= '0;

            if (state == ST_IDLE && start_req) pass_cnt <= '0;
            else if (state == ST_PASS_END)     pass_cnt <= pass_next;

            if (state == ST_IDLE) abort_pend <= 1'b0;
            else if (abort_req && (state == ST_ISSUE || state == ST_DRAIN)) abort_pend <= 1'b1;
        end
    end

    // PASSES register (frozen during a run), busy flag and sticky irq.
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            passes <= PASS_W'(1);
            busy   <= 1'b0;
            irq    <= 1'b0;
        end else begin
            if (csr_write && csr_addr == CSR_PASSES && state == ST_IDLE)
                passes <= csr_data_in[PASS_W-1:0];
            busy <= (next_state != ST_IDLE);
            // Setting wins over a clear that lands while DONE is showing.
            if (state == ST_PASS_END && last_pass) irq <= 1'b1;
            else if (clr_req && state != ST_DONE)  irq <= 1'b0;
        end
    end

    // CSR read mux.
    always_comb begin
        csr_data_out = '0;
        case (csr_addr)
            CSR_PASSES: csr_data_out[PASS_W-1:0] = passes;
            CSR_STATUS: begin
                csr_data_out[0]           = busy;
                csr_data_out[1]           = irq;
                csr_data_out[16 +: PASS_W] = pass_cnt;
            end
            CSR_INDEX:  csr_data_out[ADDR_W-1:0] = rd_index;
            default:    csr_data_out = '0;
        endcase
    end

    mand_delay #(
        .WIDTH (ADDR_W + 1),
        .DEPTH (LATENCY)
    ) u_delay (
        .clock (clock),
        .rst   (rst),
        .din   ({rd_valid, rd_index}),
        .dout  (wr_bus)
    );

    assign {wr_en, wr_index} = wr_bus;

endmodule

// File: tb/tb_mand_sequencer.sv
// Directed bench for mand_sequencer with ADDR_W=4, LATENCY=3, PASS_W=10.
module tb_mand_sequencer;
  import mand_pkg::*;

  logic        clock;
  logic        rst;
  logic        csr_write;
  logic [1:0]  csr_addr;
  logic [31:0] csr_data_in;
  logic [31:0] csr_data_out;
  logic [3:0]  rd_index;
  logic        rd_valid;
  logic [3:0]  wr_index;
  logic        wr_en;
  logic        busy;
  logic        irq;

  int n_checks = 0;
  int n_fail   = 0;

  mand_sequencer #(.ADDR_W(4), .LATENCY(3), .PASS_W(10)) dut (
    .clock        (clock),
    .rst          (rst),
    .csr_write    (csr_write),
    .csr_addr     (csr_addr),
    .csr_data_in  (csr_data_in),
    .csr_data_out (csr_data_out),
    .rd_index     (rd_index),
    .rd_valid     (rd_valid),
    .wr_index     (wr_index),
    .wr_en        (wr_en),
    .busy         (busy),
    .irq          (irq)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // one-cycle CSR write; returns at the negedge after the sampling edge
  task automatic csr_wr(input logic [1:0] a, input logic [31:0] d);
    @(negedge clock);
    csr_write   = 1'b1;
    csr_addr    = a;
    csr_data_in = d;
    @(negedge clock);
    csr_write   = 1'b0;
    csr_data_in = '0;
  endtask

  task automatic csr_rd(input logic [1:0] a, output logic [31:0] d);
    csr_addr = a;
    #1;
    d = csr_data_out;
  endtask

  // start a single pass and check every cycle of it against the timing table
  task automatic run_one_pass(input string tag);
    csr_wr(CSR_CTRL, 32'h1);
    for (int k = 1; k <= 22; k++) begin
      check_eq({tag, "_rd_valid"}, 32'(rd_valid), 32'(k <= 16));
      if (k <= 16) check_eq({tag, "_rd_index"}, 32'(rd_index), 32'(k - 1));
      check_eq({tag, "_wr_en"}, 32'(wr_en), 32'(k >= 4 && k <= 19));
      if (k >= 4 && k <= 19) check_eq({tag, "_wr_index"}, 32'(wr_index), 32'(k - 4));
      check_eq({tag, "_busy"}, 32'(busy), 32'(k <= 21));
      check_eq({tag, "_irq"}, 32'(irq), 32'(k >= 21));
      @(negedge clock);
    end
  endtask

  initial begin
    logic [31:0] rd;
    int wr_cnt;
    rst = 1'b1; csr_write = 1'b0; csr_addr = '0; csr_data_in = '0;

    // reset state
    repeat (2) @(negedge clock);
    check_eq("rst_rd_valid", 32'(rd_valid), 32'd0);
    check_eq("rst_wr_en", 32'(wr_en), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_irq", 32'(irq), 32'd0);
    csr_rd(CSR_PASSES, rd);
    check_eq("rst_passes", rd, 32'd1);
    rst = 1'b0;
    @(negedge clock);

    // single pass
    run_one_pass("p1");

    // start+abort together in IDLE does nothing
    csr_wr(CSR_CTRL, 32'h3);
    check_eq("startabort_busy", 32'(busy), 32'd0);
    check_eq("startabort_rdv", 32'(rd_valid), 32'd0);

    // irq clear
    csr_wr(CSR_CTRL, 32'h4);
    check_eq("irq_clear", 32'(irq), 32'd0);

    // three passes, with start and PASSES=5 rewritten mid-run
    csr_wr(CSR_PASSES, 32'd3);
    csr_wr(CSR_CTRL, 32'h1);
    wr_cnt = 0;
    for (int k = 1; k <= 62; k++) begin
      check_eq("p3_rd_valid", 32'(rd_valid), 32'(k <= 60 && ((k - 1) % 20) < 16));
      if (wr_en) begin
        check_eq("p3_wr_index", 32'(wr_index), 32'(wr_cnt % 16));
        wr_cnt++;
      end
      check_eq("p3_busy", 32'(busy), 32'(k <= 61));
      check_eq("p3_irq", 32'(irq), 32'(k >= 61));
      if (k == 21 || k == 41 || k == 61) begin
        csr_rd(CSR_STATUS, rd);
        check_eq("p3_pass_field", 32'(rd[25:16]), 32'(k / 20));
      end
      if (k == 10) begin
        csr_write = 1'b1; csr_addr = CSR_CTRL; csr_data_in = 32'h1;
      end else if (k == 11) begin
        csr_write = 1'b1; csr_addr = CSR_PASSES; csr_data_in = 32'd5;
      end else if (k == 12) begin
        csr_write = 1'b0; csr_data_in = '0;
      end
      @(negedge clock);
    end
    check_eq("p3_wr_count", 32'(wr_cnt), 32'd48);
    csr_rd(CSR_PASSES, rd);
    check_eq("p3_passes_kept", rd, 32'd3);

    // abort while rd_index = 7
    csr_wr(CSR_CTRL, 32'h4);
    csr_wr(CSR_PASSES, 32'd1);
    csr_wr(CSR_CTRL, 32'h1);
    for (int k = 1; k <= 14; k++) begin
      check_eq("ab_rd_valid", 32'(rd_valid), 32'(k <= 8));
      if (k <= 8) check_eq("ab_rd_index", 32'(rd_index), 32'(k - 1));
      check_eq("ab_wr_en", 32'(wr_en), 32'(k >= 4 && k <= 11));
      if (k >= 4 && k <= 11) check_eq("ab_wr_index", 32'(wr_index), 32'(k - 4));
      check_eq("ab_busy", 32'(busy), 32'(k <= 11));
      check_eq("ab_irq", 32'(irq), 32'd0);
      if (k == 8) begin
        csr_write = 1'b1; csr_addr = CSR_CTRL; csr_data_in = 32'h2;
      end else if (k == 9) begin
        csr_write = 1'b0; csr_data_in = '0;
      end
      @(negedge clock);
    end

    // reset mid-ISSUE
    csr_wr(CSR_PASSES, 32'd2);
    csr_wr(CSR_CTRL, 32'h1);
    repeat (4) @(negedge clock);
    check_eq("mr_pre_wr_en", 32'(wr_en), 32'd1);
    rst = 1'b1;
    #1;
    check_eq("mr_rd_valid", 32'(rd_valid), 32'd0);
    check_eq("mr_rd_index", 32'(rd_index), 32'd0);
    check_eq("mr_wr_en", 32'(wr_en), 32'd0);
    check_eq("mr_wr_index", 32'(wr_index), 32'd0);
    check_eq("mr_busy", 32'(busy), 32'd0);
    check_eq("mr_irq", 32'(irq), 32'd0);
    @(negedge clock);
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clock);
      check_eq("mr_post_wr_en", 32'(wr_en), 32'd0);
      check_eq("mr_post_rd_valid", 32'(rd_valid), 32'd0);
    end
    csr_rd(CSR_PASSES, rd);
    check_eq("mr_passes", rd, 32'd1);
    run_one_pass("rerun");

    // PASSES=0 acts as one pass; clear in the DONE cycle is ignored
    csr_wr(CSR_CTRL, 32'h4);
    csr_wr(CSR_PASSES, 32'd0);
    csr_wr(CSR_CTRL, 32'h1);
    repeat (20) @(negedge clock);
    check_eq("p0_irq_done", 32'(irq), 32'd1);
    check_eq("p0_busy_done", 32'(busy), 32'd1);
    csr_rd(CSR_STATUS, rd);
    check_eq("p0_pass_field", 32'(rd[25:16]), 32'd1);
    csr_write = 1'b1; csr_addr = CSR_CTRL; csr_data_in = 32'h4;
    @(negedge clock);
    csr_write = 1'b0; csr_data_in = '0;
    check_eq("p0_irq_kept", 32'(irq), 32'd1);
    check_eq("p0_busy_after", 32'(busy), 32'd0);
    csr_wr(CSR_CTRL, 32'h4);
    check_eq("p0_irq_cleared", 32'(irq), 32'd0);
    csr_rd(CSR_PASSES, rd);
    check_eq("p0_passes_reg", rd, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
